// File: rtl/fifo_uart_pkg.sv
// Shared FSM state encoding and line levels for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    WAIT,
    START,
    DATA,
    STOP,
    PARITY
  } state_t;

  localparam logic TX_IDLE_LVL = 1'b1;
  localparam logic START_LVL   = 1'b0;

endpackage

// File: rtl/fifo_uart_baud_cnt.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1 while enabled, flags the final
// count (bit_tick) and the count before it (pre_tick).
module fifo_uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_tick,
  output logic pre_tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  assign bit_tick = (cnt == CW'(CLKS_PER_BIT - 1));
  assign pre_tick = (cnt == CW'(CLKS_PER_BIT - 2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= bit_tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from the async FIFO read side and serialises them as start/data/stop
// frames. Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit before STOP.
module fifo_uart_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic              rd_clk,
  input  logic              reset,
  input  logic              enable_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  input  logic              fifo_empty_i,
  output logic              rd_en_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              frame_done_o
);
  import fifo_uart_pkg::*;

  localparam int unsigned BW = $clog2(DATA_W + 1);

  state_t            state, state_n;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic [BW-1:0]     bit_q, bit_n;
  logic              bit_tick, pre_tick, cnt_clear, cnt_en;
  logic              tx_n;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              par_q;
`endif

  fifo_uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (rd_clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .bit_tick(bit_tick),
    .pre_tick(pre_tick)
  );

  always_comb begin
    state_n = state;
    shift_n = shift_q;
    bit_n   = bit_q;
    cnt_en  = 1'b0;
    case (state)
      IDLE:  if (enable_i && !fifo_empty_i) state_n = POP;
      POP:   state_n = WAIT;
      WAIT: begin
        state_n = START;
        shift_n = fifo_data_i;
        bit_n   = '0;
      end
      START: begin
        cnt_en = 1'b1;
        if (bit_tick) state_n = DATA;
      end
      DATA: begin
        cnt_en = 1'b1;
        if (bit_tick) begin
          shift_n = shift_q >> 1;
          bit_n   = bit_q + BW'(1);
          if (bit_q == BW'(DATA_W - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        cnt_en = 1'b1;
        if (bit_tick) state_n = STOP;
      end
`endif
      STOP: begin
        cnt_en = 1'b1;
        if (bit_tick) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    cnt_clear = (state_n != state);
  end

  // Outputs are registered from next-state values so they line up with the state cycle.
  always_comb begin
    tx_n = TX_IDLE_LVL;
    case (state_n)
      START:  tx_n = START_LVL;
      DATA:   tx_n = shift_n[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx_n = par_q;
`endif
      default: tx_n = TX_IDLE_LVL;
    endcase
  end

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shift_q      <= '0;
      bit_q        <= '0;
      rd_en_o      <= 1'b0;
      tx_o         <= TX_IDLE_LVL;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      state        <= state_n;
      shift_q      <= shift_n;
      bit_q        <= bit_n;
      rd_en_o      <= (state_n == POP);
      tx_o         <= tx_n;
      busy_o       <= (state_n != IDLE);
      frame_done_o <= (state == STOP) && pre_tick;
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (state == WAIT) begin
      par_q <= ^fifo_data_i;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO environment, cycle-level frame model, vector table,
// directed corner sequences and randomized traffic.
module tb_fifo_uart_tx;

  localparam int unsigned CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * CPB;
  localparam int LAST = 1 + FLEN;

  logic       rd_clk       = 1'b0;
  logic       reset        = 1'b1;
  logic       enable_i     = 1'b0;
  logic [7:0] fifo_data_i  = '0;
  logic       fifo_empty_i = 1'b1;
  logic       rd_en_o, tx_o, busy_o, frame_done_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:1023];
  int wr_ptr = 0, rd_ptr = 0, m_ptr = 0, pop_cnt = 0;
  logic [7:0] pend;
  bit pend_v = 0;

  int k = -1;
  logic [7:0] m_word = '0;

  always #5 rd_clk = ~rd_clk;

  fifo_uart_tx #(
    .DATA_W      (8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .rd_clk      (rd_clk),
    .reset       (reset),
    .enable_i    (enable_i),
    .fifo_data_i (fifo_data_i),
    .fifo_empty_i(fifo_empty_i),
    .rd_en_o     (rd_en_o),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .frame_done_o(frame_done_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level of frame bit i for word w: start, LSB-first data, [even parity], stop.
  function automatic logic line_bit(input int i, input logic [7:0] w);
    if (i == 0) return 1'b0;
    if (i <= 8) return w[i-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (i == 9) return ^w;
`endif
    return 1'b1;
  endfunction

  // FIFO read side: data for a pop appears at the negedge after the pop edge.
  always @(negedge rd_clk) begin
    if (pend_v) begin
      fifo_data_i = pend;
      pend_v = 0;
    end else begin
      fifo_data_i = 8'($urandom);
    end
    if (rd_en_o === 1'b1 && !reset) begin
      check("pop_when_nonempty", 32'(rd_ptr != wr_ptr), 1);
      pend = mem[rd_ptr % 1024];
      rd_ptr++;
      pend_v = 1;
      pop_cnt++;
    end
    fifo_empty_i = (rd_ptr == wr_ptr);
  end

  // Reference model: k = cycles since the pop cycle of the current frame, -1 when idle.
  always @(posedge rd_clk) begin
    if (reset) k = -1;
    else if (k >= 0) k = (k == LAST) ? -1 : k + 1;
    else if (enable_i && !fifo_empty_i) begin
      k = 0;
      m_word = mem[m_ptr % 1024];
      m_ptr++;
    end
  end

  always @(negedge rd_clk) begin : monitor
    logic [3:0] exp;
    if (reset || k < 0) exp = 4'b0010;
    else begin
      exp[3] = (k == 0);
      exp[2] = 1'b1;
      exp[1] = (k < 2) ? 1'b1 : line_bit((k - 2) / CPB, m_word);
      exp[0] = (k == LAST);
    end
    check("cycle {rd_en,busy,tx,done}", {28'd0, rd_en_o, busy_o, tx_o, frame_done_o}, {28'd0, exp});
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge rd_clk);
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 1024] = d;
    wr_ptr++;
  endtask

  task automatic wait_tx_low(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge rd_clk);
      if (tx_o === 1'b0) break;
    end
    check(name, 32'(tx_o), 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
    logic       par;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int p0, done_at, ndone, t;
    logic [NBITS-1:0] rx, exp_line;

    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
    vecs[1] = '{8'h00, 10'b1000000000, 1'b0};
    vecs[2] = '{8'hFF, 10'b1111111110, 1'b0};
    vecs[3] = '{8'h3C, 10'b1001111000, 1'b0};
    vecs[4] = '{8'h07, 10'b1000001110, 1'b1};

    cycles(3);
    check("reset_outputs", {28'd0, rd_en_o, busy_o, tx_o, frame_done_o}, 32'b0010);
    reset = 1'b0;
    enable_i = 1'b1;

    // Empty FIFO: nothing happens.
    cycles(100);
    check("empty_no_pops", pop_cnt, 0);
    check("empty_idle_tx", 32'(tx_o), 1);

    // Single frames from the vector table.
    foreach (vecs[v]) begin
`ifdef FIFO_UART_TX_PARITY_EN
      exp_line = {1'b1, vecs[v].par, vecs[v].line[8:0]};
`else
      exp_line = vecs[v].line;
`endif
      p0 = pop_cnt;
      done_at = -1;
      rx = '0;
      push(vecs[v].data);
      wait_tx_low("vec_start");
      for (int j = 0; j < FLEN; j++) begin
        if (j % CPB == 0) rx[j / CPB] = tx_o;
        if (frame_done_o === 1'b1) done_at = j;
        @(negedge rd_clk);
      end
      check("vec_line", 32'(rx), 32'(exp_line));
      check("vec_done_cycle", done_at, FLEN - 1);
      check("vec_one_pop", pop_cnt - p0, 1);
      cycles(4);
    end

    // Three queued words back to back: 3-cycle idle gaps between frames.
    p0 = pop_cnt;
    push(8'h00); push(8'hFF); push(8'h3C);
    wait_tx_low("b2b_start");
    ndone = 0;
    t = 0;
    for (int j = 0; j < 400 && ndone < 3; j++) begin
      if (frame_done_o === 1'b1) begin ndone++; t = j; end
      if (ndone < 3) @(negedge rd_clk);
    end
    check("b2b_frames", ndone, 3);
    check("b2b_span", t, 3 * FLEN + 6 - 1);
    check("b2b_pops", pop_cnt - p0, 3);
    cycles(5);

    // Asynchronous reset in DATA bit 3 of 0x55.
    push(8'h55);
    wait_tx_low("rst_frame_start");
    cycles(CPB + 3 * CPB + 1);
    check("rst_pre_bit3", 32'(tx_o), 0);
    #1 reset = 1'b1;
    #1;
    check("rst_async_tx", 32'(tx_o), 1);
    check("rst_async_busy", 32'(busy_o), 0);
    cycles(2);
    reset = 1'b0;
    p0 = pop_cnt;
    cycles(10);
    check("rst_no_pop_empty", pop_cnt - p0, 0);
    push(8'h12);
    wait_tx_low("rst_next_frame");
    cycles(FLEN + 4);

    // Enable dropped during START: frame completes, no further pops.
    p0 = pop_cnt;
    push(8'h81); push(8'h42);
    wait_tx_low("en_frame_start");
    enable_i = 1'b0;
    cycles(FLEN + 30);
    check("en_one_pop", pop_cnt - p0, 1);
    check("en_idle_busy", 32'(busy_o), 0);
    check("en_idle_tx", 32'(tx_o), 1);
    enable_i = 1'b1;
    wait_tx_low("en_resume");
    check("en_second_pop", pop_cnt - p0, 2);
    cycles(FLEN + 4);

    // Randomized traffic with enable toggling; the model checks every cycle.
    for (int it = 0; it < 150; it++) begin
      int n;
      n = int'($urandom_range(0, 2));
      for (int w = 0; w < n; w++) push(8'($urandom));
      enable_i = ($urandom_range(0, 7) != 0);
      cycles(int'($urandom_range(0, 30)));
    end
    enable_i = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge rd_clk);
      if (rd_ptr == wr_ptr && busy_o === 1'b0) break;
    end
    check("drain_all_popped", rd_ptr, wr_ptr);
    check("drain_model_pops", m_ptr, rd_ptr);
    check("drain_idle", 32'(busy_o), 0);
    cycles(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
